// File: rtl/register_file_write_arbiter.sv
// ---------------------------------------------------------------------------
// register_file_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters: port A (ALU result) and port B (memory load). Both requesters
// are arbitrated round-robin in the same cycle. The winner's address and
// data are registered, and drive the register file one cycle later.
//
// A 16-entry pending-write scoreboard lets decode stall on RAW hazards.
// Decode sets a bit when it issues a producer. The bit clears on the edge
// that ends the matching write_enable cycle.
//
// Ports:
//   clk, reset_asynchronous      clock; asynchronous active-high reset
//   a_valid/a_ready/a_address/a_data   requester A (ALU) handshake
//   b_valid/b_ready/b_address/b_data   requester B (load) handshake
//   hold                         blocks all grants
//   reserve_valid/reserve_address      marks a register as pending
//   query_address0/1, busy0/1    decode hazard lookup
//   write_enable/write_address/write_data   register file write port
//   last_grant                   0 = A won most recently, 1 = B
//
// Optional feature (macro REGISTER_FILE_WRITE_BYPASS_EN):
//   Adds bypass_hit0/1 and bypass_data. A query that matches the write
//   currently on the port reports a bypass hit instead of busy, so decode
//   forwards the value rather than stalling.
// ---------------------------------------------------------------------------
module register_file_write_arbiter #(
    parameter int W    = 32,
    parameter int NREG = 16
) (
    input  logic         clk,
    input  logic         reset_asynchronous,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [3:0]   a_address,
    input  logic [W-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [3:0]   b_address,
    input  logic [W-1:0] b_data,
    input  logic         hold,
    input  logic         reserve_valid,
    input  logic [3:0]   reserve_address,
    input  logic [3:0]   query_address0,
    input  logic [3:0]   query_address1,
    output logic         busy0,
    output logic         busy1,
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    output logic         bypass_hit0,
    output logic         bypass_hit1,
    output logic [W-1:0] bypass_data,
`endif
    output logic         write_enable,
    output logic [3:0]   write_address,
    output logic [W-1:0] write_data,
    output logic         last_grant
);

    logic            grant_a;
    logic            grant_b;

    logic            write_enable_q,  write_enable_d;
    logic [3:0]      write_address_q, write_address_d;
    logic [W-1:0]    write_data_q,    write_data_d;
    logic            last_grant_q,    last_grant_d;
    logic [NREG-1:0] scoreboard_q,    scoreboard_d;

    // Round-robin arbitration. When both requesters are valid, the port that
    // did not win last time is granted. Grants are suppressed while reset is
    // asserted, so no requester sees a handshake that the flops would drop.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset_asynchronous && !hold) begin
            if (a_valid && b_valid) begin
                grant_a = last_grant_q;
                grant_b = !last_grant_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Write stage: capture the winner. Address and data hold when idle.
    always_comb begin
        write_enable_d  = grant_a | grant_b;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        last_grant_d    = last_grant_q;
        if (grant_a) begin
            write_address_d = a_address;
            write_data_d    = a_data;
            last_grant_d    = 1'b0;
        end else if (grant_b) begin
            write_address_d = b_address;
            write_data_d    = b_data;
            last_grant_d    = 1'b1;
        end
    end

    // Scoreboard update. The set is applied after the clear, so a new
    // reservation of the register being written survives the same edge.
    always_comb begin
        scoreboard_d = scoreboard_q;
        if (write_enable_q) begin
            scoreboard_d[write_address_q] = 1'b0;
        end
        if (reserve_valid) begin
            scoreboard_d[reserve_address] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            write_enable_q  <= 1'b0;
            write_address_q <= 4'd0;
            write_data_q    <= '0;
            last_grant_q    <= 1'b1;
            scoreboard_q    <= '0;
        end else begin
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            last_grant_q    <= last_grant_d;
            scoreboard_q    <= scoreboard_d;
        end
    end

    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign last_grant    = last_grant_q;

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    // A query that hits the write currently on the port is served by
    // forwarding, so it is not reported as busy.
    assign bypass_hit0 = write_enable_q && (write_address_q == query_address0);
    assign bypass_hit1 = write_enable_q && (write_address_q == query_address1);
    assign bypass_data = write_data_q;
    assign busy0       = scoreboard_q[query_address0] && !bypass_hit0;
    assign busy1       = scoreboard_q[query_address1] && !bypass_hit1;
`else
    assign busy0       = scoreboard_q[query_address0];
    assign busy1       = scoreboard_q[query_address1];
`endif

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_register_file_write_arbiter
//
// Directed testbench for register_file_write_arbiter. Inputs are driven just
// after the rising edge. Outputs are sampled before the next edge.
// Define REGISTER_FILE_WRITE_BYPASS_EN to cover the bypass outputs.
// ---------------------------------------------------------------------------
module tb_register_file_write_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset_asynchronous;
    logic         a_valid, a_ready;
    logic [3:0]   a_address;
    logic [W-1:0] a_data;
    logic         b_valid, b_ready;
    logic [3:0]   b_address;
    logic [W-1:0] b_data;
    logic         hold;
    logic         reserve_valid;
    logic [3:0]   reserve_address;
    logic [3:0]   query_address0, query_address1;
    logic         busy0, busy1;
    logic         write_enable;
    logic [3:0]   write_address;
    logic [W-1:0] write_data;
    logic         last_grant;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    logic         bypass_hit0, bypass_hit1;
    logic [W-1:0] bypass_data;
`endif

    int passed = 0;
    int total  = 0;

    register_file_write_arbiter #(.W(W), .NREG(16)) dut (
        .clk                (clk),
        .reset_asynchronous (reset_asynchronous),
        .a_valid            (a_valid),
        .a_ready            (a_ready),
        .a_address          (a_address),
        .a_data             (a_data),
        .b_valid            (b_valid),
        .b_ready            (b_ready),
        .b_address          (b_address),
        .b_data             (b_data),
        .hold               (hold),
        .reserve_valid      (reserve_valid),
        .reserve_address    (reserve_address),
        .query_address0     (query_address0),
        .query_address1     (query_address1),
        .busy0              (busy0),
        .busy1              (busy1),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        .bypass_hit0        (bypass_hit0),
        .bypass_hit1        (bypass_hit1),
        .bypass_data        (bypass_data),
`endif
        .write_enable       (write_enable),
        .write_address      (write_address),
        .write_data         (write_data),
        .last_grant         (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_asynchronous = 1'b1;
        a_valid = 1'b1; a_address = 4'd0; a_data = '0;
        b_valid = 1'b1; b_address = 4'd0; b_data = '0;
        hold = 1'b0;
        reserve_valid = 1'b0; reserve_address = 4'd0;
        query_address0 = 4'd0; query_address1 = 4'd0;
        #2;
        check("rst_we",    write_enable,  1'b0);
        check("rst_waddr", write_address, 4'd0);
        check("rst_wdata", write_data,    32'd0);
        check("rst_lg",    last_grant,    1'b1);
        check("rst_busy0", busy0,         1'b0);
        check("rst_busy1", busy1,         1'b0);
        check("rst_ardy",  a_ready,       1'b0);
        check("rst_brdy",  b_ready,       1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        reset_asynchronous = 1'b0;
        tick();

        // Single A write: address 3, latency 1, then idle.
        a_valid = 1'b1; a_address = 4'd3; a_data = 32'h12345678;
        #1;
        check("a_only_ardy", a_ready, 1'b1);
        check("a_only_brdy", b_ready, 1'b0);
        tick();
        a_valid = 1'b0;
        check("a_only_we",    write_enable,  1'b1);
        check("a_only_waddr", write_address, 4'd3);
        check("a_only_wdata", write_data,    32'h12345678);
        check("a_only_lg",    last_grant,    1'b0);
        tick();
        check("a_only_we_off", write_enable,  1'b0);
        check("a_only_hold",   write_address, 4'd3);

        // Single B write: address 9.
        b_valid = 1'b1; b_address = 4'd9; b_data = 32'h99;
        #1;
        check("b_only_brdy", b_ready, 1'b1);
        check("b_only_ardy", a_ready, 1'b0);
        tick();
        b_valid = 1'b0;
        check("b_only_waddr", write_address, 4'd9);
        check("b_only_lg",    last_grant,    1'b1);

        // Both valid for 4 cycles: A,B,A,B with no idle cycles.
        a_valid = 1'b1; a_address = 4'd1; a_data = 32'h11;
        b_valid = 1'b1; b_address = 4'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            logic exp_a;
            exp_a = (i % 2 == 0);
            #1;
            check("rr_ardy", a_ready, exp_a);
            check("rr_brdy", b_ready, !exp_a);
            tick();
            check("rr_we",    write_enable,  1'b1);
            check("rr_waddr", write_address, exp_a ? 4'd1 : 4'd2);
            check("rr_wdata", write_data,    exp_a ? 32'h11 : 32'h22);
        end
        check("rr_lg", last_grant, 1'b1);

        // Hold blocks both for 3 cycles; release grants opposite of last_grant.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ardy", a_ready, 1'b0);
            check("hold_brdy", b_ready, 1'b0);
            tick();
            check("hold_we", write_enable, 1'b0);
        end
        hold = 1'b0;
        #1;
        check("unhold_ardy", a_ready, 1'b1);
        check("unhold_brdy", b_ready, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("unhold_waddr", write_address, 4'd1);
        check("unhold_lg",    last_grant,    1'b0);

        // Scoreboard: reserve 5, write 5, then reserve 5 again during the write.
        reserve_valid = 1'b1; reserve_address = 4'd5; query_address0 = 4'd5;
        #1;
        check("sb_pre", busy0, 1'b0);
        tick();
        reserve_valid = 1'b0;
        check("sb_set", busy0, 1'b1);
        a_valid = 1'b1; a_address = 4'd5; a_data = 32'h55;
        tick();
        a_valid = 1'b0;
        check("sb_we", write_enable, 1'b1);
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        check("sb_during_write", busy0, 1'b0);
`else
        check("sb_during_write", busy0, 1'b1);
`endif
        tick();
        check("sb_cleared", busy0, 1'b0);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        reserve_valid = 1'b1; reserve_address = 4'd5;
        tick();
        reserve_valid = 1'b0;
        check("sb_set_wins", busy0, 1'b1);

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        // Bypass: reserve 7, write 7, query through port 1.
        reserve_valid = 1'b1; reserve_address = 4'd7; query_address1 = 4'd7;
        tick();
        reserve_valid = 1'b0;
        check("byp_busy_pre", busy1, 1'b1);
        a_valid = 1'b1; a_address = 4'd7; a_data = 32'hCAFE0000;
        tick();
        a_valid = 1'b0;
        check("byp_hit1", bypass_hit1, 1'b1);
        check("byp_hit0", bypass_hit0, 1'b0);
        check("byp_data", bypass_data, 32'hCAFE0000);
        check("byp_busy1", busy1, 1'b0);
        tick();
        check("byp_hit1_off", bypass_hit1, 1'b0);
        check("byp_busy1_clr", busy1, 1'b0);
`endif

        // Reset mid-write: the in-flight write and reservations are lost.
        check("mid_busy_pre", busy0, 1'b1);
        a_valid = 1'b1; a_address = 4'd4; a_data = 32'h44;
        tick();
        a_valid = 1'b0;
        check("mid_we_pre", write_enable, 1'b1);
        reset_asynchronous = 1'b1;
        #1;
        check("mid_we",    write_enable,  1'b0);
        check("mid_waddr", write_address, 4'd0);
        check("mid_wdata", write_data,    32'd0);
        check("mid_busy0", busy0,         1'b0);
        check("mid_busy1", busy1,         1'b0);
        check("mid_lg",    last_grant,    1'b1);
        a_valid = 1'b1; a_address = 4'd6; a_data = 32'h66;
        b_valid = 1'b1; b_address = 4'd8; b_data = 32'h88;
        #1;
        check("mid_ardy_rst", a_ready, 1'b0);
        check("mid_brdy_rst", b_ready, 1'b0);
        reset_asynchronous = 1'b0;
        #1;
        check("post_ardy", a_ready, 1'b1);
        check("post_brdy", b_ready, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("post_waddr", write_address, 4'd6);
        check("post_wdata", write_data,    32'h66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
